// File: rtl/dmem_pkg.sv
// Shared types and helpers for the dmem_ctrl data memory block.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_t;

    localparam int WAIT_W = 4;

    // Byte-enable merge: a lane takes new data only when the access is a write and its enable is set.
    function automatic logic be_lane_write(input logic we, input logic be_bit);
        return we & be_bit;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed synchronous RAM, one byte-wide bank per lane, byte-enable write and registered read.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    localparam int BE_W  = DATA_W / 8,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [BE_W-1:0]   be,
    output logic [DATA_W-1:0] rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < BE_W; gi++) begin : g_lane
            logic [7:0] mem_lane [DEPTH];
            logic [7:0] rd_lane_q;

            always_ff @(posedge clk) begin
                if (be_lane_write(we, be[gi])) begin
                    mem_lane[addr] <= wdata[gi*8 +: 8];
                end
                if (re) begin
                    rd_lane_q <= mem_lane[addr];
                end
            end

            assign rdata[gi*8 +: 8] = rd_lane_q;
        end
    endgenerate

endmodule

// File: rtl/dmem_ctrl.sv
// Single-outstanding data memory controller with valid/ready handshake and programmable wait states.
// Optional address checking (misaligned / out of range) is enabled by defining DMEM_ERR_CHECK_EN.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [31:0]         req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err
);

    localparam int BE_W  = DATA_W / 8;
    localparam int OFF   = $clog2(BE_W);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_CYCLES);

    dmem_state_t         state_q, state_d;
    logic [WAIT_W-1:0]   cnt_q, cnt_d;
    logic                we_q, we_d;
    logic                err_q, err_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [BE_W-1:0]     be_q, be_d;

    logic [IDX_W-1:0]    req_idx;
    logic                req_err;
    logic                enter_resp;
    logic                ram_we;
    logic                ram_re;
    logic [DATA_W-1:0]   ram_rdata;
    logic                unused_addr;

    assign req_idx     = IDX_W'(req_addr >> OFF);
    assign unused_addr = ^req_addr;

`ifdef DMEM_ERR_CHECK_EN
    localparam logic [31:0] OFF_MASK = 32'((64'd1 << OFF) - 64'd1);
    assign req_err = ((req_addr & OFF_MASK) != 32'd0) || ((req_addr >> OFF) >= 32'(DEPTH));
`else
    assign req_err = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        err_d      = err_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    err_d   = req_err;
                    idx_d   = req_idx;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    cnt_d   = WAIT_LOAD;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d    = RESP;
                    cnt_d      = '0;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The _d values equal the live request when accepting from IDLE with zero wait states,
    // so the memory access on the edge entering RESP always sees the right transaction.
    // Gating with rst guarantees a reset during WAIT never commits the write.
    assign ram_we = enter_resp && we_d && !err_d && !rst;
    assign ram_re = enter_resp && !we_d && !err_d && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        idx_q   <= idx_d;
        wdata_q <= wdata_d;
        be_q    <= be_d;
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (idx_d),
        .wdata (wdata_d),
        .be    (be_d),
        .rdata (ram_rdata)
    );

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = (rsp_valid && !we_q && !err_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl (DATA_W=32, DEPTH=1024, WAIT_CYCLES=1).
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;
    int lat;
    logic [31:0] held;

    always #5 clk = ~clk;

    dmem_ctrl #(
        .DATA_W      (32),
        .DEPTH       (1024),
        .WAIT_CYCLES (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present a request at a negedge, let it be accepted, then count cycles to rsp_valid.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] be, output int latency);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_be    = be;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        latency   = 1;
        while (rsp_valid !== 1'b1 && latency < 20) begin
            @(negedge clk);
            latency++;
        end
    endtask

    // Complete the handshake and confirm the block is ready again the following cycle.
    task automatic finish_rsp(input string tag);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_req_ready_after"}, 32'(req_ready), 32'd1);
        chk({tag, "_rsp_valid_after"}, 32'(rsp_valid), 32'd0);
    endtask

    task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] be,
                       input logic [31:0] exp_rdata, input logic exp_err);
        int l;
        issue(we, addr, wd, be, l);
        chk({tag, "_latency"}, 32'(l), 32'd2);
        chk({tag, "_rdata"}, rsp_rdata, exp_rdata);
        chk({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        chk({tag, "_req_ready_busy"}, 32'(req_ready), 32'd0);
        $display("txn %s we=%0b addr=0x%08h wdata=0x%08h be=%04b -> rdata=0x%08h err=%0b lat=%0d",
                 tag, we, addr, wd, be, rsp_rdata, rsp_err, l);
        finish_rsp(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_err",   32'(rsp_err),   32'd0);
        chk("reset_rsp_rdata", rsp_rdata,      32'd0);

        // Full-word write then read back
        txn("wr_full", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
        txn("rd_full", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

        // Partial byte-enable write merges lanes 0 and 2
        txn("wr_be5", 1'b1, 32'h10, 32'h11223344, 4'b0101, 32'h0, 1'b0);
        txn("rd_be5", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDE22BE44, 1'b0);

        // be=0 still responds but changes nothing
        txn("wr_be0", 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0);
        txn("rd_be0", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDE22BE44, 1'b0);

        // Backpressure: response must hold while rsp_ready is low
        rsp_ready = 1'b0;
        issue(1'b0, 32'h10, 32'h0, 4'h0, lat);
        chk("bp_latency", 32'(lat), 32'd2);
        held = rsp_rdata;
        chk("bp_rdata_first", held, 32'hDE22BE44);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rdata_stable", rsp_rdata, 32'hDE22BE44);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
        end
        $display("txn backpressure read addr=0x00000010 held rdata=0x%08h for 5 cycles", rsp_rdata);
        finish_rsp("bp");

`ifdef DMEM_ERR_CHECK_EN
        // Misaligned write targets the same word as 0x10 and must not modify it
        txn("err_misalign_wr", 1'b1, 32'h13, 32'h00000000, 4'hF, 32'h0, 1'b1);
        txn("err_misalign_chk", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDE22BE44, 1'b0);
        txn("err_range_rd", 1'b0, 32'h1000, 32'h0, 4'h0, 32'h0, 1'b1);
`else
        // Without checking, low offset bits are ignored and the index wraps
        txn("alias_wr0", 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
        txn("alias_rd1000", 1'b0, 32'h1000, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);
        txn("alias_rd13", 1'b0, 32'h13, 32'h0, 4'h0, 32'hDE22BE44, 1'b0);
`endif

        // Reset during WAIT must drop the pending write to 0x20
        txn("rst_prior_wr", 1'b1, 32'h20, 32'h55555555, 4'hF, 32'h0, 1'b0);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'hAAAAAAAA;
        req_be    = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_in_wait_state", 32'(req_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_in_wait_req_ready", 32'(req_ready), 32'd1);
        chk("rst_in_wait_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("rst_in_wait_no_rsp", 32'(rsp_valid), 32'd0);
        $display("txn reset-in-wait write addr=0x00000020 wdata=0xaaaaaaaa dropped");
        txn("rst_after_rd", 1'b0, 32'h20, 32'h0, 4'h0, 32'h55555555, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
